position_decoder: RTL and testbench

POSITION_DECODER -- requirements
Module: position_decoder

---
 rtl/pos_dec_pkg.sv | 10 +
 rtl/pos_onehot.sv | 24 ++
 rtl/position_decoder.sv | 72 +++++++
 tb/tb_position_decoder.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/pos_dec_pkg.sv
// Shared sizing and cell-number type for the board position decoder.
package pos_dec_pkg;

    localparam int unsigned NUM_CELLS = 9;
    localparam int unsigned OUT_W     = 16;
    localparam int unsigned POS_W     = 4;

    typedef logic [POS_W-1:0] cell_num_t;

endpackage

// File: rtl/pos_onehot.sv
// Combinational map from a 1-based cell number to a one-hot strobe plus an in-range flag.
module pos_onehot
    import pos_dec_pkg::*;
#(
    parameter int unsigned NUM_CELLS = pos_dec_pkg::NUM_CELLS,
    parameter int unsigned OUT_W     = pos_dec_pkg::OUT_W
) (
    input  cell_num_t          in_pos,
    output logic [OUT_W-1:0]   onehot_c,
    output logic               in_range_c
);

    always_comb begin
        in_range_c = (in_pos != '0) && (32'(in_pos) <= NUM_CELLS);
        onehot_c   = '0;
        // Bits at or above NUM_CELLS can never be selected, keeping the strobe one-hot.
        for (int unsigned i = 0; i < OUT_W; i++) begin
            if (in_range_c && (i < NUM_CELLS) && (32'(in_pos) == i + 1)) begin
                onehot_c[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/position_decoder.sv
// Accepts or rejects move requests against a per-game occupancy map, with registered responses.
module position_decoder
    import pos_dec_pkg::*;
#(
    parameter int unsigned NUM_CELLS = pos_dec_pkg::NUM_CELLS,
    parameter int unsigned OUT_W     = pos_dec_pkg::OUT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  cell_num_t            in_pos,
    input  logic                 turn_enable,
    input  logic                 clear,
    output logic [OUT_W-1:0]     temp1,
    output logic                 pos_valid,
    output logic                 pos_err,
    output logic [NUM_CELLS-1:0] occupied
);

    logic [OUT_W-1:0]     onehot_c;
    logic                 in_range_c;
    logic                 cell_taken_c;
    logic [OUT_W-1:0]     temp1_d;
    logic                 pos_valid_d;
    logic                 pos_err_d;
    logic [NUM_CELLS-1:0] occupied_d;

    pos_onehot #(
        .NUM_CELLS (NUM_CELLS),
        .OUT_W     (OUT_W)
    ) u_pos_onehot (
        .in_pos     (in_pos),
        .onehot_c   (onehot_c),
        .in_range_c (in_range_c)
    );

    // Checked against the registered map, so back-to-back repeats of a cell are rejected.
    assign cell_taken_c = |(onehot_c[NUM_CELLS-1:0] & occupied);

    // Next-state: clear beats a move; enabled requests either claim a free cell or flag an error.
    always_comb begin
        temp1_d     = '0;
        pos_valid_d = 1'b0;
        pos_err_d   = 1'b0;
        occupied_d  = occupied;
        if (clear) begin
            occupied_d = '0;
        end else if (turn_enable) begin
            if (in_range_c && !cell_taken_c) begin
                temp1_d     = onehot_c;
                pos_valid_d = 1'b1;
                occupied_d  = occupied | onehot_c[NUM_CELLS-1:0];
            end else begin
                pos_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            temp1     <= '0;
            pos_valid <= 1'b0;
            pos_err   <= 1'b0;
            occupied  <= '0;
        end else begin
            temp1     <= temp1_d;
            pos_valid <= pos_valid_d;
            pos_err   <= pos_err_d;
            occupied  <= occupied_d;
        end
    end

endmodule

// File: tb/tb_position_decoder.sv
// Directed bench for position_decoder with a queue of model-predicted responses.
module tb_position_decoder;

    localparam int unsigned NUM_CELLS = 9;
    localparam int unsigned OUT_W     = 16;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [3:0]           in_pos;
    logic                 turn_enable;
    logic                 clear;
    logic [OUT_W-1:0]     temp1;
    logic                 pos_valid;
    logic                 pos_err;
    logic [NUM_CELLS-1:0] occupied;

    typedef struct {
        logic [OUT_W-1:0]     temp1;
        logic                 valid;
        logic                 err;
        logic [NUM_CELLS-1:0] occ;
        string                tag;
    } exp_t;

    exp_t                 sb[$];
    logic [NUM_CELLS-1:0] model_occ = '0;
    int                   n_checks  = 0;
    int                   n_fail    = 0;

    position_decoder #(
        .NUM_CELLS (NUM_CELLS),
        .OUT_W     (OUT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_pos      (in_pos),
        .turn_enable (turn_enable),
        .clear       (clear),
        .temp1       (temp1),
        .pos_valid   (pos_valid),
        .pos_err     (pos_err),
        .occupied    (occupied)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour for one sampled request; result queued for the next edge.
    task automatic predict(input logic r, input logic te, input logic clr,
                           input logic [3:0] pos, input string tag);
        exp_t e;
        int   p;
        p       = int'(pos);
        e.temp1 = '0;
        e.valid = 1'b0;
        e.err   = 1'b0;
        e.tag   = tag;
        if (!r) begin
            model_occ = '0;
        end else if (clr) begin
            model_occ = '0;
        end else if (te) begin
            if (p >= 1 && p <= NUM_CELLS && !model_occ[p-1]) begin
                e.temp1        = OUT_W'(1) << (p - 1);
                e.valid        = 1'b1;
                model_occ[p-1] = 1'b1;
            end else begin
                e.err = 1'b1;
            end
        end
        e.occ = model_occ;
        sb.push_back(e);
    endtask

    task automatic step(input logic r, input logic te, input logic clr,
                        input logic [3:0] pos, input string tag);
        exp_t e;
        rst_n       = r;
        turn_enable = te;
        clear       = clr;
        in_pos      = pos;
        predict(r, te, clr, pos, tag);
        @(posedge clk);
        #1;
        n_checks++;
        assert (sb.size() != 0) else begin
            n_fail++;
            $error("FAIL %s: observed empty scoreboard expected entry", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({e.tag, ".temp1"},     32'(temp1),     32'(e.temp1));
            check({e.tag, ".pos_valid"}, 32'(pos_valid), 32'(e.valid));
            check({e.tag, ".pos_err"},   32'(pos_err),   32'(e.err));
            check({e.tag, ".occupied"},  32'(occupied),  32'(e.occ));
            check({e.tag, ".exclusive"}, 32'(pos_valid & pos_err), 32'(0));
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        turn_enable = 1'b0;
        clear       = 1'b0;
        in_pos      = '0;
        @(posedge clk);
        #1;

        // Reset while a request is present must swallow it.
        step(1'b0, 1'b1, 1'b0, 4'd1, "reset");
        step(1'b0, 1'b1, 1'b1, 4'd2, "reset_hold");

        for (int i = 1; i <= 9; i++) step(1'b1, 1'b1, 1'b0, 4'(i), $sformatf("fill%0d", i));
        check("full_map", 32'(occupied), 32'h1FF);

        step(1'b1, 1'b1, 1'b0, 4'd0, "pos0");
        for (int i = 10; i <= 15; i++) step(1'b1, 1'b1, 1'b0, 4'(i), $sformatf("oob%0d", i));

        step(1'b1, 1'b1, 1'b1, 4'd3, "clear_drop");
        step(1'b1, 1'b1, 1'b0, 4'd3, "after_clear3");

        step(1'b1, 1'b1, 1'b0, 4'd5, "first5");
        step(1'b1, 1'b1, 1'b0, 4'd5, "repeat5");

        for (int i = 1; i <= 9; i++) step(1'b1, 1'b0, 1'b0, 4'(i), $sformatf("idle%0d", i));

        step(1'b1, 1'b0, 1'b1, 4'd0, "clear_idle");
        step(1'b1, 1'b1, 1'b0, 4'd1, "g1");
        step(1'b1, 1'b1, 1'b0, 4'd3, "g3");
        step(1'b1, 1'b1, 1'b0, 4'd5, "g5");
        step(1'b1, 1'b1, 1'b0, 4'd7, "g7");
        check("map_055", 32'(occupied), 32'h055);
        step(1'b0, 1'b1, 1'b0, 4'd9, "midgame_reset");
        step(1'b1, 1'b0, 1'b0, 4'd9, "post_reset_idle");
        step(1'b1, 1'b1, 1'b0, 4'd9, "post_reset9");
        step(1'b1, 1'b1, 1'b1, 4'd2, "clear_over_move");
        step(1'b1, 1'b1, 1'b0, 4'd9, "reaccept9");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
